// File: rtl/irq_pending_latch.sv
// irq_pending_latch
//   Latches rising edges on raw request lines into a pending vector that
//   stays set until acknowledged by index. The masked pending vector feeds
//   the X input of the downstream priority encoder, and that encoder's Y
//   output returns here as ack_id. Overflow flags mark lines that rose
//   again while their previous event was still pending.
//
//   Optional feature macro: IRQ_SYNC_EN
//     defined   - 2-flop synchronizer per line ahead of the edge detector;
//                 req_in may be asynchronous; request latency 3 cycles.
//     undefined - req_in feeds the edge detector directly and must be
//                 synchronous to clk; request latency 1 cycle.
//
//   Acknowledge handshake: ack is a single-cycle strobe with no ready
//   return path. Every ack cycle clears exactly the bit named by ack_id.
//   Acking a bit that is not pending is harmless. When a new edge and a
//   clear hit the same bit in one cycle, the set wins and the new event
//   is kept.
module irq_pending_latch #(
  parameter int ID_W = 2,
  localparam int N = 2**ID_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_in,
  input  logic [N-1:0]    mask,
  output logic [N-1:0]    pend_out,
  output logic            irq,
  input  logic            ack,
  input  logic [ID_W-1:0] ack_id,
  output logic [N-1:0]    ovf,
  input  logic            ovf_clr
);

  logic [N-1:0] req_s;
  logic [N-1:0] req_prev;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] pending;

`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync_q1;
  logic [N-1:0] sync_q2;

  // Two-stage synchronizer; resets to ones so a line held high through
  // reset is not seen as a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= req_in;
      sync_q2 <= sync_q1;
    end
  end

  assign req_s = sync_q2;
`else
  assign req_s = req_in;
`endif

  // Previous-cycle copy of the detector input; ones at reset so that a
  // line must go low and then high again before it produces an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev <= '1;
    end else begin
      req_prev <= req_s;
    end
  end

  assign rise = req_s & ~req_prev;

  // One-hot clear decode of the acknowledged index.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = ack && (ack_id == ID_W'(i));
    end
  end

  // Pending vector: a rise sets the bit, an ack clears it, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  // Sticky overflow: a rise on a bit that remains pending. A new set
  // wins over ovf_clr in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~{N{ovf_clr}}) | (rise & pending & ~clr);
    end
  end

  // Mask only gates the outputs; latched state is unaffected.
  assign pend_out = pending & mask;
  assign irq      = |pend_out;

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch
//   Directed scenarios followed by randomized traffic, checked against a
//   per-line event model. The model tracks each line as "what the detector
//   sees" (req_in delayed through a history queue) and applies the event
//   rules line by line.
module tb_irq_pending_latch;

  localparam int ID_W = 2;
  localparam int N    = 2**ID_W;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_in;
  logic [N-1:0]    mask;
  logic [N-1:0]    pend_out;
  logic            irq;
  logic            ack;
  logic [ID_W-1:0] ack_id;
  logic [N-1:0]    ovf;
  logic            ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit           m_pend [N];
  bit           m_ovf  [N];
  bit           m_prev [N];
  logic [N-1:0] hist_q[$];
  logic [N-1:0] exp_q[$];

  irq_pending_latch #(.ID_W(ID_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .mask     (mask),
    .pend_out (pend_out),
    .irq      (irq),
    .ack      (ack),
    .ack_id   (ack_id),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] pack(input bit v [N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_ovf[i]  = 1'b0;
      m_prev[i] = 1'b1;
    end
    hist_q.delete();
    for (int k = 0; k < LAT - 1; k++) hist_q.push_back('1);
  endtask

  // One clock edge worth of model evolution using the applied inputs.
  task automatic model_edge(input logic [N-1:0] r, input logic a,
                            input logic [ID_W-1:0] id, input logic oc);
    logic [N-1:0] seen;
    hist_q.push_back(r);
    seen = hist_q.pop_front();
    if (oc) for (int i = 0; i < N; i++) m_ovf[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      bit new_event;
      bit acked;
      new_event = seen[i] && !m_prev[i];
      acked     = a && (int'(id) == i);
      if (new_event && m_pend[i] && !acked) m_ovf[i] = 1'b1;
      if (new_event)  m_pend[i] = 1'b1;
      else if (acked) m_pend[i] = 1'b0;
      m_prev[i] = seen[i];
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model; mask applied here.
  task automatic check_model(input string tag);
    logic [N-1:0] e;
    exp_q.push_back(pack(m_pend) & mask);
    e = exp_q.pop_front();
    check({tag, "_pend"}, pend_out, e);
    check({tag, "_irq"}, {{(N-1){1'b0}}, irq}, {{(N-1){1'b0}}, |e});
    check({tag, "_ovf"}, ovf, pack(m_ovf));
  endtask

  // Driver: apply inputs at the falling edge, clock once, check at the
  // next falling edge.
  task automatic step(input string tag, input logic [N-1:0] r,
                      input logic a = 1'b0, input logic [ID_W-1:0] id = '0,
                      input logic oc = 1'b0);
    req_in  = r;
    ack     = a;
    ack_id  = id;
    ovf_clr = oc;
    @(posedge clk);
    model_edge(r, a, id, oc);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step("idle", '0);
  endtask

  initial begin
    // reset block
    rst_n   = 1'b0;
    req_in  = 4'hF;
    mask    = 4'hF;
    ack     = 1'b0;
    ack_id  = '0;
    ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pend", pend_out, 4'h0);
    check("rst_irq", {3'b0, irq}, 4'h0);
    check("rst_ovf", ovf, 4'h0);
    rst_n = 1'b1;

    // line held high through reset produces no event
    for (int k = 0; k < 10; k++) begin
      step("held_high", 4'hF);
      check("held_high_zero", pend_out, 4'h0);
    end
    idle(2);

    // single request then ack
    step("s2_pulse", 4'b0100);
    idle(LAT - 1);
    check("s2_pend", pend_out, 4'b0100);
    check("s2_irq", {3'b0, irq}, 4'b0001);
    step("s2_ack", 4'b0000, 1'b1, 2'd2);
    check("s2_ack_pend", pend_out, 4'h0);
    check("s2_ack_irq", {3'b0, irq}, 4'h0);

    // two requests cleared in priority order
    step("s3_pulse", 4'b1001);
    idle(LAT - 1);
    check("s3_pend", pend_out, 4'b1001);
    step("s3_ack3", 4'b0000, 1'b1, 2'd3);
    check("s3_after3", pend_out, 4'b0001);
    step("s3_ack0", 4'b0000, 1'b1, 2'd0);
    check("s3_after0", pend_out, 4'b0000);
    step("s3_ack2", 4'b0000, 1'b1, 2'd2);
    check("s3_after2", pend_out, 4'b0000);
    check("s3_ovf", ovf, 4'b0000);

    // overflow, ovf_clr, and set-wins on a simultaneous ack
    step("s4_first", 4'b0010);
    step("s4_low", 4'b0000);
    step("s4_second", 4'b0010);
    idle(LAT - 1);
    check("s4_ovf", ovf, 4'b0010);
    check("s4_pend", pend_out, 4'b0010);
    step("s4_clr", 4'b0000, 1'b0, 2'd0, 1'b1);
    check("s4_ovf_clr", ovf, 4'b0000);
    idle(LAT);
    // align the detected rise with the ack edge
    req_in = 4'b0010;
    if (LAT > 1) begin
      for (int k = 0; k < LAT - 1; k++) step("s4_pre", 4'b0010);
      step("s4_same", 4'b0010, 1'b1, 2'd1);
    end else begin
      step("s4_same", 4'b0010, 1'b1, 2'd1);
    end
    check("s4_setwins_pend", pend_out, 4'b0010);
    check("s4_setwins_ovf", ovf, 4'b0000);
    step("s4_done", 4'b0000, 1'b1, 2'd1);
    idle(LAT);

    // masking gates outputs only; unmask exposes immediately
    mask = 4'b0111;
    step("s5_pulse", 4'b1000);
    idle(LAT - 1);
    check("s5_masked_pend", pend_out, 4'h0);
    check("s5_masked_irq", {3'b0, irq}, 4'h0);
    mask = 4'hF;
    #1;
    check("s5_unmask_pend", pend_out, 4'b1000);
    check("s5_unmask_irq", {3'b0, irq}, 4'b0001);
    step("s5_ack", 4'b0000, 1'b1, 2'd3);

`ifdef IRQ_SYNC_EN
    // synchronizer latency: 0 after two edges, set after the third
    step("s6_rise", 4'b0001);
    step("s6_hold", 4'b0001);
    check("s6_after2", pend_out, 4'h0);
    step("s6_hold2", 4'b0001);
    check("s6_after3", pend_out, 4'b0001);
    step("s6_low", 4'b0000, 1'b1, 2'd0);
    idle(LAT);
`endif

    // asynchronous reset while pending = 0110
    step("ar_pulse", 4'b0110);
    idle(LAT - 1);
    check("ar_before", pend_out, 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_pend", pend_out, 4'h0);
    check("ar_irq", {3'b0, irq}, 4'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // randomized traffic, encoder-style ack loop on some cycles
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0]    r;
      logic            a;
      logic [ID_W-1:0] id;
      logic            oc;
      r  = N'($urandom_range(0, N*N - 1));
      a  = ($urandom_range(0, 2) == 0);
      id = ID_W'($urandom_range(0, N - 1));
      oc = ($urandom_range(0, 9) == 0);
      if (k % 37 == 0) mask = N'($urandom_range(0, N*N - 1));
      step("rand", r, a, id, oc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
